sigmoid_arbiter: RTL

//  Shares one registered sigmoid LUT unit between NUM_REQ neuron lanes.
//  - Round-robin arbitration issues at most one float_24_8 operand per cycle into the unit.
//  - Tracks each operand's requester id through the unit latency.
//  - Steers each result into a per-requester response FIFO with valid/ready handshake.
//  - Credit-based issue: the unit itself is never stalled.

---
 rtl/sigmoid_arbiter_if.sv | 25 ++
 rtl/sigmoid_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/sigmoid_arbiter_if.sv
// sigmoid_arbiter_if: requester, sigmoid-unit and response bundle shared by the arbiter and its environment.
interface sigmoid_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]         sig_in;
    logic [DATA_W-1:0]         sig_out;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [NUM_REQ*DATA_W-1:0] rsp_data;
    logic                      busy;

    modport master (
        output req_valid, req_data, sig_out, rsp_ready,
        input  req_ready, sig_in, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, sig_out, rsp_ready,
        output req_ready, sig_in, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: round-robin, credit-based sharing of one registered sigmoid unit between NUM_REQ lanes.
module sigmoid_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 1,
    parameter int RES_DEPTH = 2
) (
    input logic clk,
    input logic reset,
    sigmoid_arbiter_if.slave bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int PW = RES_DEPTH > 1 ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      winner;
    logic               grant_any;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [CW-1:0]      count    [NUM_REQ];
    logic [CW-1:0]      inflight [NUM_REQ];
    logic [PW-1:0]      rd_ptr   [NUM_REQ];
    logic [PW-1:0]      wr_ptr   [NUM_REQ];
    logic [DATA_W-1:0]  mem      [NUM_REQ][RES_DEPTH];
    logic [LATENCY-1:0] pipe_v;
    logic [IW-1:0]      pipe_id  [LATENCY];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits use registered occupancy only, so a pop frees its slot one cycle later.
    always_comb begin
        bus.busy      = |pipe_v;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        eligible      = '0;
        push          = '0;
        pop           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = reset && bus.req_valid[i] &&
                          (({1'b0, count[i]} + {1'b0, inflight[i]}) < (CW+1)'(RES_DEPTH));
            push[i] = pipe_v[LATENCY-1] && (pipe_id[LATENCY-1] == IW'(i));
            pop[i] = bus.rsp_ready[i] && (count[i] != '0);
            bus.rsp_valid[i] = count[i] != '0;
            bus.rsp_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
            bus.busy = bus.busy | (count[i] != '0);
        end
    end

    // Scan offsets high to low so the closest eligible lane to rr_ptr is the last to win.
    always_comb begin
        grant_any     = 1'b0;
        winner        = '0;
        bus.req_ready = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_any     = 1'b1;
                winner        = IW'((int'(rr_ptr) + k) % NUM_REQ);
                bus.req_ready = '0;
                bus.req_ready[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
            end
        end
        bus.sig_in = grant_any ? bus.req_data[winner*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            pipe_v <= '0;
            for (int s = 0; s < LATENCY; s++) pipe_id[s] <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                count[i]    <= '0;
                inflight[i] <= '0;
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                for (int d = 0; d < RES_DEPTH; d++) mem[i][d] <= '0;
            end
        end else begin
            if (grant_any) rr_ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            pipe_v[0]  <= grant_any;
            pipe_id[0] <= winner;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_v[s]  <= pipe_v[s-1];
                pipe_id[s] <= pipe_id[s-1];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= bus.sig_out;
                    wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
                end
                if (pop[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                count[i]    <= count[i] + CW'(push[i]) - CW'(pop[i]);
                inflight[i] <= inflight[i] + CW'(grant_any && (winner == IW'(i))) - CW'(push[i]);
            end
        end
    end
endmodule
